// File: rtl/be8_ram_dbg.sv
// ---------------------------------------------------------------------------
// be8_ram_dbg
//   Parametrised RAM plus memory address register (MAR) for the BE8 core.
//   The CPU reaches the RAM through the MI/RI/RO bus strobes. A debugger can
//   take ownership through a request/ack handshake and then stream
//   set-address / write / read commands with an auto-incrementing MAR.
//   With CLEAR_ON_RESET=1 every word is zeroed after reset, one per cycle.
//
// Parameters
//   DATA_WIDTH      bus / memory word width (must be >= ADDR_WIDTH)
//   ADDR_WIDTH      MAR width, DEPTH = 2**ADDR_WIDTH (must be >= 2)
//   CLEAR_ON_RESET  1: zero sweep after reset, 0: contents left as they are
//
// Ports
//   CLK, RESET      rising-edge clock, synchronous active-high reset
//   MI, RI, RO      CPU strobes: load MAR, write mem[MAR], read mem[MAR]
//   BUS_IN          shared bus value (address or write data)
//   BUS_OUT/BUS_OE  mem[MAR] (asynchronous read) and its drive enable
//   MAR_OUT         current MAR for display
//   BUSY            clear sweep in progress
//   DEBUG_REQUEST   debugger asks for the RAM, DEBUG_ACK grants it
//   DEBUG_CMD       00 set-address, 01 write+inc, 10 read+inc, 11 nop
//   DEBUG_DATA      address (low ADDR_WIDTH bits) or write data
//   DEBUG_VALID     command valid, accepted when DEBUG_READY is high
//   DEBUG_RDATA     read result, qualified by the DEBUG_RVALID pulse
// ---------------------------------------------------------------------------
module be8_ram_dbg #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  MI,
    input  logic                  RI,
    input  logic                  RO,
    input  logic [DATA_WIDTH-1:0] BUS_IN,
    output logic [DATA_WIDTH-1:0] BUS_OUT,
    output logic                  BUS_OE,
    output logic [ADDR_WIDTH-1:0] MAR_OUT,
    output logic                  BUSY,
    input  logic                  DEBUG_REQUEST,
    output logic                  DEBUG_ACK,
    input  logic [1:0]            DEBUG_CMD,
    input  logic [DATA_WIDTH-1:0] DEBUG_DATA,
    input  logic                  DEBUG_VALID,
    output logic                  DEBUG_READY,
    output logic [DATA_WIDTH-1:0] DEBUG_RDATA,
    output logic                  DEBUG_RVALID
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'b00,
        ST_IDLE  = 2'b01,
        ST_DEBUG = 2'b10
    } state_t;

    localparam logic [1:0] CMD_SET = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   mar_r;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic                    ack_r;
    logic                    busy_r;
    logic                    rvalid_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic [DATA_WIDTH-1:0]   mem_r [DEPTH];

    logic                    dbg_fire_s;
    logic                    mem_we_s;
    logic [ADDR_WIDTH-1:0]   mem_waddr_s;
    logic [DATA_WIDTH-1:0]   mem_wdata_s;

    // ack_r is high exactly while the debugger owns the RAM, so it doubles
    // as the command-accept qualifier.
    assign dbg_fire_s = ack_r & DEBUG_VALID;

    // Select the single memory write port source: sweep, CPU or debugger.
    // A write coinciding with RESET is dropped so that reset never alters
    // contents on its own.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = mar_r;
        mem_wdata_s = BUS_IN;
        if (RESET) begin
            mem_we_s = 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = clr_cnt_r;
                    mem_wdata_s = DATA_ZERO;
                end
                ST_IDLE: begin
                    mem_we_s = RI;
                end
                ST_DEBUG: begin
                    mem_wdata_s = DEBUG_DATA;
                    if (dbg_fire_s && (DEBUG_CMD == CMD_WR)) begin
                        mem_we_s = 1'b1;
                    end else begin
                        mem_we_s = 1'b0;
                    end
                end
                default: begin
                    mem_we_s = 1'b0;
                end
            endcase
        end
    end

    // Memory array write; no reset so it maps onto plain RAM.
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[mem_waddr_s] <= mem_wdata_s;
        end
    end

    // Ownership FSM with MAR, clear counter and debug read-back registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r   <= RESET_STATE;
            mar_r     <= ADDR_ZERO;
            clr_cnt_r <= ADDR_ZERO;
            ack_r     <= 1'b0;
            busy_r    <= CLEAR_ON_RESET;
            rvalid_r  <= 1'b0;
            rdata_r   <= DATA_ZERO;
        end else begin
            rvalid_r <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + ADDR_ONE;
                    if (clr_cnt_r == ADDR_LAST) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        mar_r   <= ADDR_ZERO;
                    end
                end
                ST_IDLE: begin
                    // The RI write above uses the pre-edge MAR, so MI&RI
                    // writes the old address before MAR moves.
                    if (MI) begin
                        mar_r <= BUS_IN[ADDR_WIDTH-1:0];
                    end
                    if (DEBUG_REQUEST) begin
                        state_r <= ST_DEBUG;
                        ack_r   <= 1'b1;
                    end
                end
                ST_DEBUG: begin
                    if (DEBUG_VALID) begin
                        case (DEBUG_CMD)
                            CMD_SET: begin
                                mar_r <= DEBUG_DATA[ADDR_WIDTH-1:0];
                            end
                            CMD_WR: begin
                                mar_r <= mar_r + ADDR_ONE;
                            end
                            CMD_RD: begin
                                rdata_r  <= mem_r[mar_r];
                                rvalid_r <= 1'b1;
                                mar_r    <= mar_r + ADDR_ONE;
                            end
                            default: begin
                                mar_r <= mar_r;
                            end
                        endcase
                    end
                    // A command in the releasing cycle still executes;
                    // MAR is intentionally left where the debugger put it.
                    if (!DEBUG_REQUEST) begin
                        state_r <= ST_IDLE;
                        ack_r   <= 1'b0;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to CPU ownership.
                    state_r <= ST_IDLE;
                    ack_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign BUS_OUT      = mem_r[mar_r];
    assign BUS_OE       = RO & (state_r == ST_IDLE);
    assign MAR_OUT      = mar_r;
    assign BUSY         = busy_r;
    assign DEBUG_ACK    = ack_r;
    assign DEBUG_READY  = ack_r;
    assign DEBUG_RDATA  = rdata_r;
    assign DEBUG_RVALID = rvalid_r;

endmodule

// File: tb/tb_be8_ram_dbg.sv
// ---------------------------------------------------------------------------
// tb_be8_ram_dbg
//   Directed bench for be8_ram_dbg. Two instances: dut (CLEAR_ON_RESET=0)
//   for CPU/debug paths and c_dut (CLEAR_ON_RESET=1) for the clear sweep.
//   Stimulus pushes expected BUS_OUT / DEBUG_RDATA values into queues; a
//   monitor pops and compares whenever BUS_OE or DEBUG_RVALID is high.
// ---------------------------------------------------------------------------
module tb_be8_ram_dbg;

    logic       clk;
    logic       reset, mi, ri, ro, dreq, dvalid;
    logic [7:0] bus_in, ddata;
    logic [1:0] dcmd;
    logic [7:0] bus_out, drdata;
    logic       bus_oe, busy, dack, dready, drvalid;
    logic [3:0] mar;

    logic       c_reset, c_mi, c_ro;
    logic [7:0] c_bus_in;
    logic [7:0] c_bus_out, c_drdata;
    logic       c_bus_oe, c_busy, c_dack, c_dready, c_drvalid;
    logic [3:0] c_mar;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] bus_q [$];
    logic [7:0] rd_q  [$];
    logic [7:0] c_q   [$];

    be8_ram_dbg #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b0)) dut (
        .CLK(clk), .RESET(reset), .MI(mi), .RI(ri), .RO(ro), .BUS_IN(bus_in),
        .BUS_OUT(bus_out), .BUS_OE(bus_oe), .MAR_OUT(mar), .BUSY(busy),
        .DEBUG_REQUEST(dreq), .DEBUG_ACK(dack), .DEBUG_CMD(dcmd),
        .DEBUG_DATA(ddata), .DEBUG_VALID(dvalid), .DEBUG_READY(dready),
        .DEBUG_RDATA(drdata), .DEBUG_RVALID(drvalid)
    );

    be8_ram_dbg #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1)) c_dut (
        .CLK(clk), .RESET(c_reset), .MI(c_mi), .RI(1'b0), .RO(c_ro),
        .BUS_IN(c_bus_in), .BUS_OUT(c_bus_out), .BUS_OE(c_bus_oe),
        .MAR_OUT(c_mar), .BUSY(c_busy), .DEBUG_REQUEST(1'b0), .DEBUG_ACK(c_dack),
        .DEBUG_CMD(2'b11), .DEBUG_DATA(8'h00), .DEBUG_VALID(1'b0),
        .DEBUG_READY(c_dready), .DEBUG_RDATA(c_drdata), .DEBUG_RVALID(c_drvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg(input logic [1:0] cmd, input logic [7:0] data);
        dvalid = 1'b1;
        dcmd   = cmd;
        ddata  = data;
        tick();
    endtask

    task automatic cpu_read(input logic [7:0] addr, input logic [7:0] exp);
        mi = 1'b1; bus_in = addr; ro = 1'b0;
        tick();
        mi = 1'b0; ro = 1'b1;
        bus_q.push_back(exp);
        tick();
        ro = 1'b0;
    endtask

    // Monitor: compare every presented output against the scoreboard.
    always @(negedge clk) begin
        if (bus_oe === 1'b1) begin
            if (bus_q.size() == 0) check("bus_oe_unexpected", {31'd0, bus_oe}, 32'd0);
            else check("bus_out", {24'd0, bus_out}, {24'd0, bus_q.pop_front()});
        end
        if (drvalid === 1'b1) begin
            if (rd_q.size() == 0) check("rvalid_unexpected", {31'd0, drvalid}, 32'd0);
            else check("debug_rdata", {24'd0, drdata}, {24'd0, rd_q.pop_front()});
        end
        if (c_bus_oe === 1'b1) begin
            if (c_q.size() == 0) check("clr_bus_oe_unexpected", {31'd0, c_bus_oe}, 32'd0);
            else check("clr_bus_out", {24'd0, c_bus_out}, {24'd0, c_q.pop_front()});
        end
    end

    initial begin
        int  cnt;
        bit  done;
        reset = 1'b1; mi = 1'b0; ri = 1'b0; ro = 1'b0; bus_in = 8'h00;
        dreq = 1'b0; dvalid = 1'b0; dcmd = 2'b11; ddata = 8'h00;
        c_reset = 1'b1; c_mi = 1'b0; c_ro = 1'b0; c_bus_in = 8'h00;
        tick();
        tick();

        // ---------------- clear sweep (c_dut) ----------------
        // RO/MI held during the sweep must be ignored.
        c_reset = 1'b0; c_ro = 1'b1; c_mi = 1'b1; c_bus_in = 8'h07;
        repeat (5) tick();
        // Reset mid-sweep restarts it from address 0.
        c_reset = 1'b1;
        tick();
        c_reset = 1'b0;
        cnt = 0; done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (c_busy) cnt++;
            else done = 1'b1;
            if (!done) begin
                tick();
                if (cnt == 8) begin c_ro = 1'b0; c_mi = 1'b0; end
            end
        end
        check("clr_sweep_finished", {31'd0, done}, 32'd1);
        check("clr_busy_cycles", cnt, 32'd16);
        check("clr_mar_after", {28'd0, c_mar}, 32'd0);
        check("clr_ack", {31'd0, c_dack}, 32'd0);
        check("clr_ready", {31'd0, c_dready}, 32'd0);
        check("clr_rvalid", {31'd0, c_drvalid}, 32'd0);
        check("clr_rdata", {24'd0, c_drdata}, 32'd0);
        for (int a = 0; a < 16; a++) begin
            tick();
            c_ro = 1'b0; c_mi = 1'b1; c_bus_in = 8'(a);
            tick();
            c_mi = 1'b0; c_ro = 1'b1;
            c_q.push_back(8'h00);
        end
        tick();
        c_ro = 1'b0;

        // ---------------- main dut: reset state ----------------
        @(negedge clk);
        check("rst_ack", {31'd0, dack}, 32'd0);
        check("rst_mar", {28'd0, mar}, 32'd0);
        check("rst_rvalid", {31'd0, drvalid}, 32'd0);
        check("rst_rdata", {24'd0, drdata}, 32'd0);
        check("rst_busy_noclear", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, dready}, 32'd0);
        tick();
        reset = 1'b0;

        // ---------------- CPU path ----------------
        mi = 1'b1; bus_in = 8'h05;
        tick();
        mi = 1'b0; ri = 1'b1; bus_in = 8'hA7;
        @(negedge clk);
        check("cpu_mar_load", {28'd0, mar}, 32'd5);
        tick();
        ri = 1'b0; ro = 1'b1;
        bus_q.push_back(8'hA7);
        @(negedge clk);
        check("cpu_bus_oe", {31'd0, bus_oe}, 32'd1);
        tick();
        ro = 1'b0; mi = 1'b1; ri = 1'b1; bus_in = 8'h03;
        tick();
        mi = 1'b0; ri = 1'b0;
        @(negedge clk);
        check("cpu_mi_ri_mar", {28'd0, mar}, 32'd3);
        tick();
        mi = 1'b1; bus_in = 8'h05;
        tick();
        mi = 1'b0; ro = 1'b1;
        bus_q.push_back(8'h03);          // MI&RI wrote 0x03 to old MAR 5
        tick();
        ri = 1'b1; bus_in = 8'h5A;       // RO&RI: old word until the edge
        bus_q.push_back(8'h03);
        tick();
        ri = 1'b0;
        bus_q.push_back(8'h5A);
        tick();
        ro = 1'b0;

        // ---------------- debug load ----------------
        dreq = 1'b1;
        @(negedge clk);
        check("dbg_ack_not_yet", {31'd0, dack}, 32'd0);
        tick();
        @(negedge clk);
        check("dbg_ack", {31'd0, dack}, 32'd1);
        check("dbg_ready", {31'd0, dready}, 32'd1);
        tick();
        dbg(2'b00, 8'h0E);
        dbg(2'b01, 8'h11);
        dbg(2'b01, 8'h22);
        dbg(2'b01, 8'h33);
        dvalid = 1'b0;
        @(negedge clk);
        check("dbg_mar_wrap", {28'd0, mar}, 32'd1);
        tick();
        dbg(2'b11, 8'h77);
        dvalid = 1'b0;
        @(negedge clk);
        check("dbg_nop_mar", {28'd0, mar}, 32'd1);
        tick();

        // ---------------- debug readback ----------------
        dbg(2'b00, 8'h0E);
        dvalid = 1'b1; dcmd = 2'b10;
        rd_q.push_back(8'h11);
        tick();
        rd_q.push_back(8'h22);
        @(negedge clk);
        check("rvalid_cycle1", {31'd0, drvalid}, 32'd1);
        tick();
        rd_q.push_back(8'h33);
        @(negedge clk);
        check("rvalid_cycle2", {31'd0, drvalid}, 32'd1);
        tick();
        dvalid = 1'b0;
        @(negedge clk);
        check("rvalid_cycle3", {31'd0, drvalid}, 32'd1);
        tick();
        @(negedge clk);
        check("rvalid_drop", {31'd0, drvalid}, 32'd0);
        check("dbg_rd_mar", {28'd0, mar}, 32'd1);
        tick();

        // ---------------- arbitration ----------------
        dbg(2'b00, 8'h0E);
        dvalid = 1'b0; ri = 1'b1; ro = 1'b1; bus_in = 8'hFF;
        @(negedge clk);
        check("arb_bus_oe", {31'd0, bus_oe}, 32'd0);
        tick();
        ri = 1'b0; ro = 1'b0; dreq = 1'b0;
        @(negedge clk);
        check("arb_ack_held", {31'd0, dack}, 32'd1);
        tick();
        dvalid = 1'b1; dcmd = 2'b01; ddata = 8'h99;   // must be ignored
        @(negedge clk);
        check("arb_ack_drop", {31'd0, dack}, 32'd0);
        check("arb_ready_drop", {31'd0, dready}, 32'd0);
        tick();
        dvalid = 1'b0;
        @(negedge clk);
        check("arb_mar_kept", {28'd0, mar}, 32'd14);
        tick();
        cpu_read(8'h0E, 8'h11);
        cpu_read(8'h0F, 8'h22);
        cpu_read(8'h00, 8'h33);

        // ---------------- reset mid-debug ----------------
        dreq = 1'b1;
        tick();
        tick();
        dbg(2'b00, 8'h08);
        dbg(2'b01, 8'h44);
        dbg(2'b01, 8'h55);
        dbg(2'b00, 8'h08);
        dvalid = 1'b1; dcmd = 2'b10;
        rd_q.push_back(8'h44);
        tick();
        dcmd = 2'b01; ddata = 8'h66; reset = 1'b1; dreq = 1'b0;
        tick();
        reset = 1'b0; dvalid = 1'b0;
        @(negedge clk);
        check("rstdbg_ack", {31'd0, dack}, 32'd0);
        check("rstdbg_mar", {28'd0, mar}, 32'd0);
        check("rstdbg_rvalid", {31'd0, drvalid}, 32'd0);
        check("rstdbg_rdata", {24'd0, drdata}, 32'd0);
        tick();
        cpu_read(8'h08, 8'h44);
        cpu_read(8'h09, 8'h55);
        cpu_read(8'h0E, 8'h11);
        cpu_read(8'h05, 8'h5A);

        tick();
        tick();
        check("bus_q_drained", bus_q.size(), 32'd0);
        check("rd_q_drained", rd_q.size(), 32'd0);
        check("clr_q_drained", c_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
